// File: rtl/axi_stream_pkt_arbiter_pkg.sv
// axi_stream_pkt_arbiter_pkg: FSM states and default stream types for the packet arbiter
package axi_stream_pkt_arbiter_pkg;
  typedef enum logic {Idle, Lock} arb_state_e;
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic [3:0]  keep;
    logic        last;
    logic [3:0]  id;
    logic [3:0]  dest;
    logic [0:0]  user;
  } axis_t_t;
  typedef struct packed {
    axis_t_t t;
    logic    tvalid;
  } axis_req_t;
  typedef struct packed {
    logic tready;
  } axis_rsp_t;
endpackage

// File: rtl/axi_stream_rr_pick.sv
// axi_stream_rr_pick: first set request at or above the pointer, wrapping to index 0
module axi_stream_rr_pick #(
  parameter int unsigned NumInp   = 4,
  parameter int unsigned IdxWidth = 2
) (
  input  logic [NumInp-1:0]   req_i,
  input  logic [IdxWidth-1:0] ptr_i,
  output logic [IdxWidth-1:0] idx_o,
  output logic                vld_o
);
  int j;
  logic [IdxWidth-1:0] w_j;
  // Scan from the farthest offset down so the nearest request wins last
  always_comb begin
    idx_o = ptr_i;
    vld_o = |req_i;
    j = 0;
    w_j = '0;
    for (int k = NumInp - 1; k >= 0; k--) begin
      j = int'(ptr_i) + k;
      j = (j >= int'(NumInp)) ? j - int'(NumInp) : j;
      w_j = IdxWidth'(j);
      if (req_i[w_j]) idx_o = w_j;
    end
  end
endmodule

// File: rtl/axi_stream_pkt_arbiter.sv
// axi_stream_pkt_arbiter: packet-granular round-robin merge of NumInp AXI streams
module axi_stream_pkt_arbiter
  import axi_stream_pkt_arbiter_pkg::*;
#(
  parameter int unsigned NumInp = 4,
  parameter type axi_stream_req_t = axis_req_t,
  parameter type axi_stream_rsp_t = axis_rsp_t,
  localparam int unsigned IdxWidth = (NumInp > 1) ? $clog2(NumInp) : 1
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic            [NumInp-1:0]        cfg_en_i,
  input  axi_stream_req_t [NumInp-1:0]        in_req_i,
  output axi_stream_rsp_t [NumInp-1:0]        in_rsp_o,
  output axi_stream_req_t                     out_req_o,
  input  axi_stream_rsp_t                     out_rsp_i,
  output logic            [IdxWidth-1:0]      sel_o,
  output logic                                busy_o
);
  arb_state_e          r_state, w_state;
  logic [IdxWidth-1:0] r_grant, w_grant, r_rr, w_rr, w_pick;
  logic [NumInp-1:0]   w_req;
  logic                w_pick_vld, w_last_hs;

  always_comb
    for (int i = 0; i < NumInp; i++) w_req[i] = in_req_i[i].tvalid & cfg_en_i[i];

  axi_stream_rr_pick #(.NumInp(NumInp), .IdxWidth(IdxWidth)) u_pick (
    .req_i(w_req),
    .ptr_i(r_rr),
    .idx_o(w_pick),
    .vld_o(w_pick_vld)
  );

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      r_state <= Idle;
      r_grant <= '0;
      r_rr    <= '0;
    end else begin
      r_state <= w_state;
      r_grant <= w_grant;
      r_rr    <= w_rr;
    end

  assign busy_o    = (r_state == Lock);
  assign sel_o     = r_grant;
  assign w_last_hs = busy_o & in_req_i[r_grant].tvalid & out_rsp_i.tready & in_req_i[r_grant].t.last;

  // Payload always follows the granted input; only valid/ready are gated by Lock
  always_comb begin
    w_state = r_state;
    w_grant = r_grant;
    w_rr    = r_rr;
    out_req_o        = in_req_i[r_grant];
    out_req_o.tvalid = busy_o & in_req_i[r_grant].tvalid;
    in_rsp_o         = '0;
    in_rsp_o[r_grant].tready = busy_o & out_rsp_i.tready;
    if (!busy_o && w_pick_vld) begin
      w_state = Lock;
      w_grant = w_pick;
    end
    if (w_last_hs) begin
      w_state = Idle;
      w_rr    = (r_grant == IdxWidth'(NumInp - 1)) ? '0 : r_grant + IdxWidth'(1);
    end
  end
endmodule

// File: tb/tb_axi_stream_pkt_arbiter.sv
// tb_axi_stream_pkt_arbiter: directed packet scenarios with an output-beat scoreboard
module tb_axi_stream_pkt_arbiter;
  import axi_stream_pkt_arbiter_pkg::*;
  logic                  clk_i = 1'b0;
  logic                  rst_ni = 1'b0;
  logic      [3:0]       cfg_en;
  axis_req_t [3:0]       in_req;
  axis_rsp_t [3:0]       in_rsp;
  axis_req_t             out_req;
  axis_rsp_t             out_rsp;
  logic      [1:0]       sel;
  logic                  busy;
  int n_chk = 0, n_err = 0;
  int len[4], beat[4], pkt[4], left[4];
  logic [31:0] obs[$];
  logic [3:0]  rdy_seen;

  axi_stream_pkt_arbiter #(
    .NumInp(4), .axi_stream_req_t(axis_req_t), .axi_stream_rsp_t(axis_rsp_t)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .cfg_en_i(cfg_en), .in_req_i(in_req), .in_rsp_o(in_rsp),
    .out_req_o(out_req), .out_rsp_i(out_rsp), .sel_o(sel), .busy_o(busy)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] rdy_vec();
    return {in_rsp[3].tready, in_rsp[2].tready, in_rsp[1].tready, in_rsp[0].tready};
  endfunction

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      in_req[i] = '0;
      in_req[i].tvalid = left[i] > 0;
      in_req[i].t.data = {8'(i), 8'(pkt[i]), 16'(beat[i])};
      in_req[i].t.last = beat[i] == len[i] - 1;
      in_req[i].t.id   = 4'(i);
      in_req[i].t.keep = '1;
      in_req[i].t.strb = '1;
    end
  endtask

  task automatic clear_src();
    for (int i = 0; i < 4; i++) begin
      len[i] = 1; beat[i] = 0; pkt[i] = 0; left[i] = 0;
    end
    obs.delete();
    drive();
  endtask

  // Sources advance on each accepted beat, as a real upstream would
  task automatic tick();
    logic hs[4];
    for (int i = 0; i < 4; i++) hs[i] = in_req[i].tvalid && in_rsp[i].tready;
    rdy_seen |= rdy_vec();
    if (out_req.tvalid && out_rsp.tready) obs.push_back(out_req.t.data);
    @(posedge clk_i);
    #1;
    for (int i = 0; i < 4; i++)
      if (hs[i]) begin
        if (beat[i] == len[i] - 1) begin
          beat[i] = 0; pkt[i]++; left[i]--;
        end else beat[i]++;
      end
    drive();
    #1;
  endtask

  task automatic dut_reset();
    rst_ni = 1'b0;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_tvalid", out_req.tvalid, 1'b0);
    check("rst_tready", rdy_vec(), 4'b0000);
    check("rst_sel", sel, 2'd0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    #1;
  endtask

  task automatic run_until(input logic [3:0] mask, input int budget, output int cyc);
    bit pend;
    cyc = 0;
    pend = 1'b1;
    while (cyc < budget && (busy || pend)) begin
      tick();
      cyc++;
      pend = 1'b0;
      for (int i = 0; i < 4; i++) if (mask[i] && left[i] > 0) pend = 1'b1;
    end
    check("drain", 32'(cyc < budget), 32'd1);
  endtask

  task automatic cmp_obs(input string tag, input logic [31:0] e[$]);
    check({tag, "_len"}, 32'(obs.size()), 32'(e.size()));
    for (int i = 0; i < e.size(); i++) check(tag, (i < obs.size()) ? obs[i] : 32'hxxxxxxxx, e[i]);
    obs.delete();
  endtask

  initial begin
    int cyc;
    logic [31:0] e[$];
    logic [31:0] prev_d;
    logic prev_v, rdy;
    cfg_en = 4'hF;
    out_rsp.tready = 1'b1;
    rdy_seen = '0;
    clear_src();
    // S1: single 3-beat packet on input 2, then rr pointer at 3
    left[2] = 1; len[2] = 3;
    drive();
    dut_reset();
    check("s1_idle_busy", busy, 1'b0);
    check("s1_idle_tvalid", out_req.tvalid, 1'b0);
    tick();
    check("s1_busy", busy, 1'b1);
    check("s1_sel", sel, 2'd2);
    check("s1_tvalid", out_req.tvalid, 1'b1);
    check("s1_data0", out_req.t.data, 32'h02000000);
    check("s1_tready", rdy_vec(), 4'b0100);
    tick();
    tick();
    check("s1_busy_mid", busy, 1'b1);
    tick();
    check("s1_busy_end", busy, 1'b0);
    left[0] = 1; left[3] = 1;
    drive();
    run_until(4'b1001, 20, cyc);
    check("s1_cycles", cyc, 4);
    e = '{32'h02000000, 32'h02000001, 32'h02000002, 32'h03000000, 32'h00000000};
    cmp_obs("s1_obs", e);
    // S2: all inputs, 2-beat packets, one bubble per packet
    clear_src();
    dut_reset();
    len = '{2, 2, 2, 2};
    left = '{2, 1, 1, 1};
    drive();
    run_until(4'b1111, 60, cyc);
    check("s2_cycles", cyc, 15);
    e = '{32'h00000000, 32'h00000001, 32'h01000000, 32'h01000001, 32'h02000000,
          32'h02000001, 32'h03000000, 32'h03000001, 32'h00010000, 32'h00010001};
    cmp_obs("s2_obs", e);
    // S3: only odd inputs enabled
    clear_src();
    dut_reset();
    cfg_en = 4'b1010;
    left = '{2, 2, 2, 2};
    drive();
    rdy_seen = '0;
    run_until(4'b1010, 40, cyc);
    check("s3_rdy_seen", rdy_seen, 4'b1010);
    check("s3_left0", left[0], 2);
    e = '{32'h01000000, 32'h03000000, 32'h01010000, 32'h03010000};
    cmp_obs("s3_obs", e);
    // S4: backpressure during a 4-beat packet; enable dropped mid-packet
    cfg_en = 4'hF;
    clear_src();
    dut_reset();
    left[1] = 1; len[1] = 4; left[2] = 1; left[3] = 1;
    drive();
    tick();
    check("s4_sel", sel, 2'd1);
    for (int k = 0; k < 8; k++) begin
      rdy = (k % 2) == 0;
      out_rsp.tready = rdy;
      if (k == 1) cfg_en = 4'b1101;
      if (k == 3) cfg_en = 4'hF;
      #1;
      prev_d = out_req.t.data;
      prev_v = out_req.tvalid;
      tick();
      if (!rdy && prev_v) begin
        check("s4_stable_d", out_req.t.data, prev_d);
        check("s4_stable_v", out_req.tvalid, 1'b1);
      end
      check("s4_others", {in_rsp[3].tready, in_rsp[2].tready, in_rsp[0].tready}, 3'b000);
    end
    out_rsp.tready = 1'b1;
    #1;
    run_until(4'b1110, 30, cyc);
    e = '{32'h01000000, 32'h01000001, 32'h01000002, 32'h01000003, 32'h02000000, 32'h03000000};
    cmp_obs("s4_obs", e);
    // S5: reset mid-packet, tail re-arbitrated from pointer 0
    clear_src();
    dut_reset();
    left[1] = 1;
    drive();
    run_until(4'b0010, 10, cyc);
    left[2] = 1; len[2] = 5;
    drive();
    tick();
    check("s5_sel", sel, 2'd2);
    tick();
    tick();
    left[1] = 1;
    drive();
    rst_ni = 1'b0;
    #1;
    check("s5_rst_tvalid", out_req.tvalid, 1'b0);
    check("s5_rst_busy", busy, 1'b0);
    check("s5_rst_tready", rdy_vec(), 4'b0000);
    tick();
    rst_ni = 1'b1;
    #1;
    tick();
    check("s5_rearb_sel", sel, 2'd1);
    run_until(4'b0110, 30, cyc);
    e = '{32'h01000000, 32'h02000000, 32'h02000001, 32'h01010000,
          32'h02000002, 32'h02000003, 32'h02000004};
    cmp_obs("s5_obs", e);
    // S6: single-beat packets alternate and take two cycles each
    clear_src();
    dut_reset();
    left[0] = 2; left[1] = 2;
    drive();
    run_until(4'b0011, 30, cyc);
    check("s6_cycles", cyc, 8);
    e = '{32'h00000000, 32'h01000000, 32'h00010000, 32'h01010000};
    cmp_obs("s6_obs", e);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
